// File: rtl/wide_add_pkg.sv
// Shared types and default sizing for the sequential wide adder.
// Holds the FSM state encoding and the default slice width and count.
package wide_add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } add_state_t;

    localparam int WA_N = 8;
    localparam int WA_K = 4;

endpackage

// File: rtl/rca_nb.sv
// n-bit ripple-carry adder slice.
// Purely combinational; a single ripple chain from i_ci to o_co.
module rca_nb #(
    parameter int n = 8
) (
    input  logic [n-1:0] i_a,
    input  logic [n-1:0] i_b,
    input  logic         i_ci,
    output logic [n-1:0] o_s,
    output logic         o_co
);

    logic [n:0] w_c;

    assign w_c[0] = i_ci;

    for (genvar g = 0; g < n; g++) begin : g_fa
        assign o_s[g]   = i_a[g] ^ i_b[g] ^ w_c[g];
        assign w_c[g+1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
    end

    assign o_co = w_c[n];

endmodule

// File: rtl/wide_add_seq.sv
// Sequential (n*k)-bit adder built from one n-bit slice over k cycles.
// Carry is registered between slices; results appear only at completion.
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int n = WA_N,
    parameter int k = WA_K
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [n*k-1:0]   a,
    input  logic [n*k-1:0]   b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [n*k-1:0]   sum,
    output logic             co,
    output logic             ovf
);

    localparam int W  = n * k;
    localparam int CW = (k > 1) ? $clog2(k) : 1;
    localparam logic [CW-1:0] LAST = CW'(k - 1);

    add_state_t     r_state;
    logic           r_busy;
    logic           r_done;
    logic [W-1:0]   r_a_sh;
    logic [W-1:0]   r_b_sh;
    logic           r_carry;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_res;
    logic           r_a_msb;
    logic           r_b_msb;
    logic [W-1:0]   r_sum;
    logic           r_co;
    logic           r_ovf;

    logic [n-1:0]   w_s;
    logic           w_co;
    logic           w_accept;
    logic           w_run;
    logic           w_last;
    logic [W-1:0]   w_res_nx;

    rca_nb #(.n(n)) u_slice (
        .i_a  (r_a_sh[n-1:0]),
        .i_b  (r_b_sh[n-1:0]),
        .i_ci (r_carry),
        .o_s  (w_s),
        .o_co (w_co)
    );

    assign w_accept = (r_state == IDLE) && start;
    assign w_run    = (r_state == RUN);
    assign w_last   = w_run && (r_cnt == LAST);

    // Slice sum enters at the top; after k shifts chunk 0 sits at the bottom.
    assign w_res_nx = W'({w_s, r_res} >> n);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_last) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_a_msb <= a[W-1];
            r_b_msb <= b[W-1];
        end else if (w_run) begin
            r_a_sh  <= r_a_sh >> n;
            r_b_sh  <= r_b_sh >> n;
            r_carry <= w_co;
            r_cnt   <= r_cnt + CW'(1);
            r_res   <= w_res_nx;
        end
    end

    // Outputs move only on the final slice edge, so no partial sums leak.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= '0;
            r_co  <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_sum <= w_res_nx;
            r_co  <= w_co;
            r_ovf <= (r_a_msb == r_b_msb) && (w_res_nx[W-1] != r_a_msb);
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign co   = r_co;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_wide_add_seq.sv
// Scoreboard bench for wide_add_seq with n=8, k=4.
// Driver pushes expected results; a negedge monitor pops on done.
module tb_wide_add_seq;

    localparam int N = 8;
    localparam int K = 4;
    localparam int W = N * K;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;

    wide_add_seq #(.n(N), .k(K)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .co    (co),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        int           cyc;
    } exp_t;

    exp_t         q[$];
    int           tests = 0;
    int           fails = 0;
    int           ncyc  = 0;
    logic [W-1:0] h_sum = '0;
    logic         h_co  = 1'b0;
    logic         h_ovf = 1'b0;
    logic         prev_done = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (rst) begin
            tests++;
            if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 ||
                co !== 1'b0 || ovf !== 1'b0) begin
                fails++;
                $display("FAIL reset: busy=%b done=%b sum=%h co=%b ovf=%b, want all zero",
                         busy, done, sum, co, ovf);
            end
            q.delete();
            h_sum = '0;
            h_co  = 1'b0;
            h_ovf = 1'b0;
        end else if (done) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL spurious_done: done=1 at cycle %0d, want no done", ncyc);
            end else begin
                e = q.pop_front();
                if (sum !== e.s || co !== e.c || ovf !== e.v ||
                    ncyc != e.cyc || busy !== 1'b1) begin
                    fails++;
                    $display("FAIL result: got sum=%h co=%b ovf=%b cyc=%0d busy=%b, want sum=%h co=%b ovf=%b cyc=%0d busy=1",
                             sum, co, ovf, ncyc, busy, e.s, e.c, e.v, e.cyc);
                end
                h_sum = e.s;
                h_co  = e.c;
                h_ovf = e.v;
            end
        end else begin
            tests++;
            if (sum !== h_sum || co !== h_co || ovf !== h_ovf) begin
                fails++;
                $display("FAIL hold: got sum=%h co=%b ovf=%b, want sum=%h co=%b ovf=%b",
                         sum, co, ovf, h_sum, h_co, h_ovf);
            end
            if (prev_done) begin
                tests++;
                if (busy !== 1'b0) begin
                    fails++;
                    $display("FAIL busy_fall: busy=%b one cycle after done, want 0", busy);
                end
            end
        end
        prev_done = done && !rst;
    end

    // Called just after a negedge; returns just after a later negedge.
    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                      input logic tc);
        int           guard;
        logic [W:0]   full;
        exp_t         e;
        guard = 0;
        while (busy && guard < 50) begin
            @(negedge clk); #1;
            guard++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL busy_timeout: busy=%b, want 0 within 50 cycles", busy);
        end
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        cin   = tc;
        full  = {1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tc};
        e.s   = full[W-1:0];
        e.c   = full[W];
        e.v   = (ta[W-1] == tb_v[W-1]) && (full[W-1] != ta[W-1]);
        e.cyc = ncyc + K + 1;
        q.push_back(e);
        @(negedge clk); #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        cin   = 1'($urandom);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((q.size() != 0 || busy) && g < 100) begin
            @(negedge clk); #1;
            g++;
        end
        if (q.size() != 0 || busy) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: pending=%0d busy=%b, want 0 and 0",
                     q.size(), busy);
            q.delete();
        end
        @(negedge clk); #1;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'($urandom);
        a     = $urandom;
        b     = $urandom;
        cin   = 1'($urandom);
        repeat (2) begin
            @(negedge clk); #1;
            start = 1'($urandom);
            a     = $urandom;
            b     = $urandom;
        end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk); #1;

        op(32'h0000_00FF, 32'h0000_0001, 1'b0);
        wait_idle();
        op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        wait_idle();
        op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        wait_idle();
        op(32'h8000_0000, 32'h8000_0000, 1'b0);
        wait_idle();

        op(32'h1234_5678, 32'h1111_1111, 1'b0);
        @(negedge clk); #1;
        start = 1'b1;
        a     = '1;
        b     = '1;
        @(negedge clk); #1;
        start = 1'b0;
        wait_idle();

        op($urandom, $urandom, 1'($urandom));
        @(negedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk); #1;
        end
        op(32'd5, 32'd7, 1'b0);
        wait_idle();

        for (int i = 0; i < 150; i++) begin
            op($urandom, $urandom, 1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                wait_idle();
            end
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wide_add_seq.md
# wide_add_seq

Multi-cycle wide adder that computes an (n·k)-bit sum plus carry-in using one n-bit ripple-carry adder slice, `rca_nb`, over k clock cycles. Each cycle it feeds the slice one n-bit operand chunk, starting at the least-significant chunk, and registers the slice carry-out as the next cycle's carry-in. It sits directly upstream of `rca_nb`: it sequences that stage's inputs and consumes its sum and carry outputs. This gives wide additions with narrow adder hardware behind a start/done handshake.

## Interface
Parameters:
- `n`, default 8: slice width in bits. Must be ≥ 1.
- `k`, default 4: number of slices. Must be ≥ 1. Total operand width is W = n·k.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request a new operation. Sampled only in IDLE.
- `a`  in  W: operand A. Sampled on the edge that accepts `start`.
- `b`  in  W: operand B. Sampled on the edge that accepts `start`.
- `cin`  in  1: carry into bit 0. Sampled on the edge that accepts `start`.
- `busy`  out  1: high in RUN and DONE.
- `done`  out  1: one-cycle pulse; result is valid while high.
- `sum`  out  W: registered result, held until the next accepted `start`.
- `co`  out  1: carry out of bit W-1.
- `ovf`  out  1: two's-complement overflow of the W-bit add.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE, with `start`=1:
  - Latch `a` and `b` into operand shift registers and `cin` into the carry register.
  - Clear the slice counter.
  - Transition to RUN.
- IDLE, with `start`=0: remain in IDLE.
- RUN, each cycle:
  - Drive `rca_nb` with `a_sh[n-1:0]`, `b_sh[n-1:0]` and the carry register.
  - Shift `a_sh` and `b_sh` right by n bits.
  - Shift the slice sum into the top of the internal result shift register.
  - Load the carry register from the slice `co`.
  - Increment the counter.
- RUN, when counter = k-1:
  - On that edge, load the output registers: `sum` takes the full result including the final slice, `co` takes the final slice carry-out.
  - Set `ovf` = (A[W-1] == B[W-1]) && (sum[W-1] != A[W-1]), using the latched A and B.
  - Transition to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE unconditionally.
- `start` during RUN or DONE is ignored and is not queued. Operands presented with it are discarded.
- Width rules:
  - Arithmetic is modulo 2^W, with carry out on `co`.
  - The counter is $clog2(k) bits wide, with a minimum of 1.
  - With k=1, RUN lasts one cycle.
- `sum`, `co` and `ovf` change only on the final RUN edge or on reset. They never show partial results.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `sum`=0, `co`=0, `ovf`=0. Internal shift, carry and counter registers are cleared.
- `rst` has priority over every other input in every state.
  - If asserted mid-RUN or in DONE, the FSM is in IDLE after that edge and all outputs are at reset values.
  - No `done` is produced for the aborted operation.
- `start` accepted at edge E0: `busy`=1 from E0.
- Slice i (i = 0..k-1) is computed in the cycle between edges Ei and E(i+1).
- Results are loaded at edge Ek, and `done`=1 in the cycle between Ek and E(k+1).
- At edge E(k+1): IDLE, `busy`=0. The earliest next `start` acceptance is at E(k+2), so throughput is one operation per k+2 cycles.
- Latency from the `start` edge to the `done` cycle is k cycles. The result remains valid after `done` falls.
- The carry path is registered between slices. The combinational depth per cycle is one n-bit ripple.

## Structure
- Shared package `wide_add_pkg` holds:
  - the state enum typedef `add_state_t` {IDLE, RUN, DONE};
  - default constants `WA_N`=8 and `WA_K`=4.
- One sub-module: `rca_nb`, instantiated with `.n(n)` and driven by the low slice of the operand shift registers and the carry register.
- All remaining logic (FSM, counter, shift registers, output registers) is in one always block per concern, inside `wide_add_seq`.

## Test plan
All scenarios use n=8, k=4 (W=32).
- Reset: hold `rst` 2 cycles with random inputs → `busy`=0, `done`=0, `sum`=0, `co`=0, `ovf`=0.
- Basic: a=0x000000FF, b=0x00000001, cin=0 → `done` pulses exactly 4 cycles after the `start` edge, for one cycle; `sum`=0x00000100, `co`=0, `ovf`=0.
- Full ripple: a=0xFFFFFFFF, b=0x00000000, cin=1 → `sum`=0x00000000, `co`=1, `ovf`=0, with the carry propagating through all 4 slices.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, cin=0 → `sum`=0x80000000, `co`=0, `ovf`=1. Also a=0x80000000, b=0x80000000 → `sum`=0, `co`=1, `ovf`=1.
- Busy rejection: start a=0x12345678, b=0x11111111; pulse `start` again 2 cycles later with a=b=0xFFFFFFFF → a single `done` with `sum`=0x23456789; `busy` falls 1 cycle after `done`.
- Abort: assert `rst` in the 2nd RUN cycle → next cycle IDLE with all outputs 0 and no `done`. A following a=5, b=7 then yields `sum`=12 with correct latency.
